// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Optional feature macro: LSU_SUBWORD_EN (byte/half/word accesses).
package lsu_pkg;

  // Access-controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_t;

  // funct3 access size / sign codes
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  localparam logic [7:0] STRB_FULL = 8'hFF;

  // Per-access state needed after issue: size/sign and byte lane
  typedef struct packed {
    logic [2:0] f3;
    logic [2:0] off;
  } lsu_req_t;

  // Unshifted byte-enable mask for a size code (funct3[1:0])
  function automatic logic [7:0] size_strb(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return STRB_FULL;
    endcase
  endfunction

  // Offset bits that must be zero for natural alignment
  function automatic logic [2:0] align_bits(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane extraction: pulls the addressed bytes out of the read doubleword
// and sign/zero-extends them according to funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] lane;
  logic        sgn;

  // Shift the addressed byte lane down to bit 0, then extend by size
  always_comb begin
    lane = rdata >> {offset, 3'b000};
    sgn  = ~funct3[2];
    data = lane;
    case (funct3[1:0])
      2'd0:    data = {{56{lane[7]  & sgn}}, lane[7:0]};
      2'd1:    data = {{48{lane[15] & sgn}}, lane[15:0]};
      2'd2:    data = {{32{lane[31] & sgn}}, lane[31:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns core MemRead/MemWrite into a single held memory
// request, stalls the core until the memory answers, and returns extended
// load data. Optional macro LSU_SUBWORD_EN enables byte/half/word accesses;
// without it every access is a doubleword.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [63:0] ALUResult,
  input  logic [63:0] ReadData2,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic [63:0] ReadData,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata
);

  lsu_state_t  state, state_nxt;
  lsu_req_t    req_q;
  logic [2:0]  f3_in;
  logic [2:0]  off_in;
  logic        acc, aligned_in, req_ok, accept;
  logic [63:0] ld_data;

`ifdef LSU_SUBWORD_EN
  assign f3_in = funct3;
`else
  // Doubleword-only build: size code forced to ld/sd
  logic unused_f3;
  assign f3_in     = F3_D;
  assign unused_f3 = ^funct3;
`endif

  assign off_in     = ALUResult[2:0];
  assign acc        = MemRead | MemWrite;
  assign aligned_in = (off_in & align_bits(f3_in[1:0])) == 3'b000;
  assign req_ok     = acc & aligned_in;
  assign accept     = (state == S_IDLE) & req_ok;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: DONE always returns to IDLE so a held request is not reissued
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_ok)    state_nxt = S_REQ;
      S_REQ:   if (mem_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs: stall is combinational so the core freezes on the issue cycle
  always_comb begin
    stall      = 1'b0;
    mem_req    = 1'b0;
    misaligned = 1'b0;
    case (state)
      S_IDLE: begin
        stall      = req_ok;
        misaligned = acc & ~aligned_in & ~reset;
      end
      S_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
      end
      default: ;
    endcase
  end

  // Latch the request on accept; memory-side outputs stay constant through REQ.
  // A store wins when both MemRead and MemWrite are high.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      req_q     <= '0;
    end else if (accept) begin
      mem_we    <= MemWrite;
      mem_addr  <= {ALUResult[63:3], 3'b000};
      mem_wdata <= ReadData2 << {off_in, 3'b000};
      mem_wstrb <= size_strb(f3_in[1:0]) << off_in;
      req_q     <= '{f3: f3_in, off: off_in};
    end
  end

  load_extend u_ext (
    .rdata  (mem_rdata),
    .offset (req_q.off),
    .funct3 (req_q.f3),
    .data   (ld_data)
  );

  // Load result: captured only when a read completes, held otherwise
  always_ff @(posedge clk) begin
    if (reset)                                      ReadData <= '0;
    else if ((state == S_REQ) && mem_ready && !mem_we) ReadData <= ld_data;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit. The driver pushes the
// reference-model expectation for every request; the negedge monitor is the
// only process that compares DUT outputs against the queue.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [63:0] ALUResult = '0, ReadData2 = '0;
  logic [2:0]  funct3 = '0;
  logic        stall, misaligned, mem_req, mem_we;
  logic [63:0] ReadData, mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [63:0] mem_rdata = '0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .ReadData2(ReadData2), .funct3(funct3),
    .stall(stall), .ReadData(ReadData), .misaligned(misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          misal;
    bit          we;
    int          wt;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdval;
    logic [7:0]  wstrb;
  } exp_t;

  exp_t        expq[$];
  int          pass_cnt = 0, tot_cnt = 0;
  int          n_wr = 0, exp_wr = 0;
  int          cur_wait = 0;
  logic [63:0] cur_rdata = '0;
  bit          chk_reset = 0, post_rst = 0, final_chk = 0;

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
`ifdef LSU_SUBWORD_EN
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
`else
    return 8 + 0 * int'(f3);
`endif
  endfunction

  function automatic exp_t model(input bit wr, input logic [63:0] addr, input logic [63:0] data,
                                 input logic [2:0] f3, input int wt, input logic [63:0] rdata);
    exp_t        e;
    int          sz, off;
    logic [15:0] s;
    logic [63:0] mask, v;
    sz      = acc_size(f3);
    off     = int'(addr[2:0]);
    e.misal = (off % sz) != 0;
    e.we    = wr;
    e.wt    = wt;
    e.addr  = addr & ~64'h7;
    e.wdata = data << (8 * off);
    s       = ((16'h1 << sz) - 16'h1) << off;
    e.wstrb = s[7:0];
    mask    = (sz == 8) ? '1 : ((64'h1 << (8 * sz)) - 64'h1);
    v       = (rdata >> (8 * off)) & mask;
`ifdef LSU_SUBWORD_EN
    if (f3 < 3'd4 && sz < 8 && v[8*sz-1]) v = v | ~mask;
`endif
    e.rdval = v;
    return e;
  endfunction

  // ---------------- memory responder ----------------
  int wcnt = 0;
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      if (wcnt >= cur_wait) begin
        mem_ready = 1'b1;
        mem_rdata = cur_rdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom};
      end
      wcnt++;
    end else begin
      mem_ready = 1'b0;
      wcnt      = 0;
    end
  end

  // ---------------- monitor / checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  exp_t        h;
  bit          chk_done = 0, rd_pend = 0;
  logic [63:0] rd_exp = '0, mon_rd = '0;
  int          stall_run = 0;

  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      chk_done  = 0;
      rd_pend   = 0;
      stall_run = 0;
      mon_rd    = '0;
      if (chk_reset) begin
        chk("rst_ReadData", ReadData, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_stall", stall, 0);
      end
    end else begin
      if (post_rst) begin
        chk("rstreq_mem_req", mem_req, 0);
        chk("rstreq_stall", stall, 0);
      end
      if (chk_done) begin
        chk("done_stall", stall, 0);
        chk("done_mem_req", mem_req, 0);
        if (rd_pend) mon_rd = rd_exp;
        chk_done = 0;
        rd_pend  = 0;
      end
      chk("ReadData", ReadData, mon_rd);
      stall_run = stall ? stall_run + 1 : 0;
      if (misaligned) begin
        if (expq.size() == 0) begin
          tot_cnt++;
          $display("FAIL misaligned_unexpected: got 1 expected no pulse");
        end else begin
          chk("misaligned_kind", 1, expq[0].misal);
          chk("misaligned_stall", stall, 0);
          if (expq[0].misal) void'(expq.pop_front());
        end
      end
      if (mem_req) begin
        if (expq.size() == 0) begin
          tot_cnt++;
          $display("FAIL mem_req_unexpected: got 1 expected 0");
        end else begin
          h = expq[0];
          chk("req_not_misaligned", h.misal, 0);
          chk("mem_addr", mem_addr, h.addr);
          chk("mem_we", mem_we, h.we);
          if (h.we) begin
            chk("mem_wdata", mem_wdata, h.wdata);
            chk("mem_wstrb", mem_wstrb, h.wstrb);
          end
          if (mem_ready) begin
            void'(expq.pop_front());
            chk("stall_cycles", stall_run, h.wt + 2);
            chk_done = 1;
            if (h.we) n_wr++;
            else begin
              rd_pend = 1;
              rd_exp  = h.rdval;
            end
          end
        end
      end
      if (final_chk) begin
        chk("write_count", n_wr, exp_wr);
        chk("queue_empty", expq.size(), 0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit rd, input bit wr, input logic [63:0] addr, input logic [63:0] data,
                       input logic [2:0] f3, input int wt, input logic [63:0] rdata);
    exp_t e;
    bit   done;
    e = model(wr, addr, data, f3, wt, rdata);
    expq.push_back(e);
    if (!e.misal && wr) exp_wr++;
    cur_wait  = wt;
    cur_rdata = rdata;
    MemRead   = rd;
    MemWrite  = wr;
    ALUResult = addr;
    ReadData2 = data;
    funct3    = f3;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = !stall;
    end
    if (!done) begin
      $display("FAIL stall_timeout: stall still 1, required release within 200 cycles");
      $fatal(1, "stall never released");
    end
    @(posedge clk); #1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = {$urandom, $urandom};
    ReadData2 = {$urandom, $urandom};
    funct3    = 3'($urandom);
  endtask

  initial begin
    bit          rd, wr;
    int          sel;
    logic [2:0]  f3;
    logic [63:0] a;
    exp_t        e;

    // Reset state
    @(posedge clk); #1 chk_reset = 1;
    @(posedge clk); #1 chk_reset = 0;
    reset = 1'b0;

    // Reset while waiting in REQ abandons the load
    e = model(1'b0, 64'h20, 64'h0, 3'd3, 0, 64'h0);
    expq.push_back(e);
    cur_wait = 1000;
    MemRead = 1'b1; ALUResult = 64'h20; funct3 = 3'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; MemRead = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; post_rst = 1;
    @(posedge clk); #1 post_rst = 0;

    // Directed cases
    issue(1, 0, 64'h10, 64'h0, 3'd3, 0, 64'h1122334455667788);
    issue(0, 1, 64'h0B, 64'hAB, 3'd0, 0, 64'h0);
    issue(1, 0, 64'h03, 64'h0, 3'd0, 0, 64'h0000_0000_8000_0000);
    issue(1, 0, 64'h03, 64'h0, 3'd4, 0, 64'h0000_0000_8000_0000);
    issue(1, 0, 64'h06, 64'h0, 3'd2, 0, 64'h0);
    issue(0, 1, 64'h40, 64'hDEAD_BEEF_0123_4567, 3'd3, 4, 64'h0);
    issue(1, 1, 64'h18, 64'h5555_AAAA_1234_5678, 3'd3, 1, 64'hFFFF_0000_FFFF_0000);
    issue(1, 0, 64'h1E, 64'h0, 3'd1, 2, 64'h8001_0000_0000_0000);

    // Randomized traffic
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 4);
      rd  = (sel <= 1) || (sel == 4);
      wr  = (sel >= 2);
      f3  = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      a   = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) a[2:0] = 3'b000;
      issue(rd, wr, a, {$urandom, $urandom}, f3, $urandom_range(0, 3), {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    final_chk = 1;
    @(negedge clk); #1 final_chk = 0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish before 500000");
    $fatal(1, "global timeout");
  end

endmodule
